frame_demux: RTL
================

# frame_demux

Receive-side counterpart of the output frame builder. Consumes the 64-bit frame stream (`data_in`, `data_in_valid`, `data_in_service`) and classifies each valid frame: hit data, Aurora IDLE, register-read service frame, auto-read service frame or channel-bonding frame. Forwards hit frames, re-serialises commanded register reads into a single-register stream, and maintains a shadow copy of the eight auto-read registers. It sits at the emulator-side loopback/checker path, directly downstream of the frame builder or of the lane deserialiser.

## Interface
Parameters:
- `DROP_IDLE`, 1: when 1, IDLE frames (`64'h1E00_0000_0000_0000`) on the non-service path are not forwarded.

Ports:
- `clk`  in  1  single clock; all logic and outputs are on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `data_in`  in  64  received frame.
- `data_in_valid`  in  1  frame qualifier, one frame per asserted cycle.
- `data_in_service`  in  1  frame is a service or channel-bonding frame.
- `hit_out`  out  64  forwarded hit frame.
- `hit_out_valid`  out  1  one-cycle strobe.
- `rdreg_dv`  out  1  one register-read result.
- `rdreg_addr`  out  9  register address (bits [8:0] of the 10-bit field).
- `rdreg_data`  out  16  register value.
- `auto_read`  out  [7:0][25:0]  shadow auto-read registers, {addr[9:0], data[15:0]}.
- `auto_read_upd`  out  8  one-cycle pulse per slot written this cycle.
- `cb_seen`  out  1  one-cycle pulse per channel-bonding frame.
- `idle_seen`  out  1  one-cycle pulse per IDLE frame.
- `frame_err`  out  1  one-cycle pulse: unknown service header, or rdreg overflow.

## Operation
- Non-service valid frame:
  - IDLE → `idle_seen`. Forwarded only if `DROP_IDLE`=0.
  - Any other value → `hit_out`/`hit_out_valid`.
  - Also clears the service index `svc_idx` to 0.
- Service valid frame, decoded on header `data_in[63:56]`:
  - `8'hB4`: slots `2*svc_idx` ← [51:26] and `2*svc_idx+1` ← [25:0]. Pulse both `auto_read_upd` bits.
  - `8'h99`, only at `svc_idx`=0: read result {addr [51:42], data [41:26]}; slot 0 ← [25:0].
  - `8'hD2`, only at `svc_idx`=0: read result A = {[51:42],[41:26]}, read result B = {[25:16],[15:0]}.
  - `8'h78`: channel bonding. Pulses `cb_seen` and clears `svc_idx`.
  - Any other header, or 99/D2 at `svc_idx`≠0 → `frame_err`. No state change except `svc_idx` increment.
  - After every non-CB service frame, `svc_idx` increments and saturates at 3. A fifth consecutive B4 rewrites slots 6/7.
- Register-read re-serialiser: 2-entry pending buffer.
  - 99 loads one entry; D2 loads two (A first).
  - One entry emitted per cycle on `rdreg_*`.
  - A 99/D2 arriving while the buffer is non-empty: new reads discarded, `frame_err` pulses. Auto-read slot 0 of a 99 frame is still written.
- Bit 9 of the address field is dropped on `rdreg_addr`.

## Timing
- Reset values: all outputs 0, `auto_read` all 0, `svc_idx`=0, pending buffer empty.
- Latency, input cycle N → output registered at N+1:
  - `hit_out*`, `auto_read`, `auto_read_upd`, `cb_seen`, `idle_seen`, `frame_err`.
  - First `rdreg_dv` of a frame.
- D2 second result: N+2.
- Back-to-back valid frames every cycle are accepted. Only the rdreg buffer can overflow; for example, a D2 followed by a 99 one cycle later overflows.
- `data_in_service` is ignored when `data_in_valid`=0.
- Reset asserted mid-operation clears the pending buffer; no residual `rdreg_dv`.

## Structure
- Shared package (also used by the frame builder):
  - `IDLE_FRAME`
  - header constants `HDR_AR`=8'hB4, `HDR_RR1`=8'h99, `HDR_RR2`=8'hD2, `HDR_CB`=8'h78
  - `autoread_t` = 26-bit {addr, data}
  - `SVC_FRAMES`=4
- One natural sub-module: `rdreg_serialiser` (the 2-entry pending buffer, load/pop/overflow). The rest of the logic lives in the top-level classifier.

## Test plan
- Reset, then `data_in`=64'h0123_4567_89AB_CDEF valid non-service → `hit_out` equals it one cycle later. Then IDLE → `idle_seen`=1, `hit_out_valid`=0.
- Four service frames, each B4 with distinct {addr, data} (e.g. slot k = {10'(k), 16'hA000+k}) → `auto_read[0..7]` match. `auto_read_upd`=8'h03, 8'h0C, 8'h30, 8'hC0 on successive cycles.
- D2 frame with addr 10'h012/data 16'hBEEF and addr 10'h034/data 16'hCAFE → `rdreg_dv` at N+1 (012/BEEF) and N+2 (034/CAFE).
- 99 frame with reg 10'h005/16'h1234 and auto-read {10'h3FF,16'h5555} → one `rdreg_dv` (005/1234). `auto_read[0]`=26'h3FF5555.
- 78 frame with service set → `cb_seen` pulse, `svc_idx`=0; a following D2 decodes correctly. Header 8'h55 in a service frame → `frame_err` only.
- D2 then 99 on consecutive cycles → `frame_err` on the second, exactly two `rdreg_dv`. Assert `reset` between the two `rdreg_dv` → second suppressed.

Source files
------------

// File: rtl/frame_demux_pkg.sv
// Shared frame-format definitions for the frame builder and the receive-side demux.
package frame_demux_pkg;

  // Aurora IDLE pattern carried on the data path.
  localparam logic [63:0] IDLE_FRAME = 64'h1E00_0000_0000_0000;

  // Service frame headers in bits [63:56].
  localparam logic [7:0] HDR_AR  = 8'hB4;  // auto-read pair
  localparam logic [7:0] HDR_RR1 = 8'h99;  // one register read + auto-read slot 0
  localparam logic [7:0] HDR_RR2 = 8'hD2;  // two register reads
  localparam logic [7:0] HDR_CB  = 8'h78;  // channel bonding

  // Service frames per auto-read sweep; each carries two slots.
  localparam int SVC_FRAMES = 4;
  localparam int AR_SLOTS   = 2 * SVC_FRAMES;

  // One auto-read slot: {addr[9:0], data[15:0]}.
  typedef logic [25:0] autoread_t;

  // Single register-read result as emitted on the rdreg stream (address bit 9 dropped).
  typedef struct packed {
    logic [8:0]  addr;
    logic [15:0] data;
  } rdreg_t;

endpackage

// File: rtl/frame_demux_rdreg_serialiser.sv
// Two-entry register-read buffer: the output stage plus one pending entry.
// A load is accepted only when no entry is still waiting to be emitted.
module rdreg_serialiser
  import frame_demux_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_load1,
  input  logic   i_load2,
  input  rdreg_t i_rd_a,
  input  rdreg_t i_rd_b,
  output logic   o_ovf,
  output logic   o_dv,
  output rdreg_t o_rd
);

  logic   r_pend;
  logic   r_dv;
  rdreg_t r_buf;
  rdreg_t r_out;
  logic   w_load;
  logic   w_accept;

  assign w_load   = i_load1 | i_load2;
  // Entry already on the output has been emitted; only a waiting entry blocks new reads.
  assign o_ovf    = w_load & r_pend;
  assign w_accept = w_load & ~r_pend;
  assign o_dv     = r_dv;
  assign o_rd     = r_out;

  // First result bypasses straight to the output; a second waits one cycle in r_buf.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= 1'b0;
      r_dv   <= 1'b0;
      r_buf  <= '0;
      r_out  <= '0;
    end else if (w_accept) begin
      r_dv   <= 1'b1;
      r_out  <= i_rd_a;
      r_buf  <= i_rd_b;
      r_pend <= i_load2;
    end else if (r_pend) begin
      r_dv   <= 1'b1;
      r_out  <= r_buf;
      r_pend <= 1'b0;
    end else begin
      r_dv   <= 1'b0;
    end
  end

endmodule

// File: rtl/frame_demux.sv
// Receive-side frame classifier: forwards hits, tracks auto-read shadow
// registers and hands commanded register reads to the serialiser.
module frame_demux
  import frame_demux_pkg::*;
#(
  parameter bit DROP_IDLE = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [63:0]                   data_in,
  input  logic                          data_in_valid,
  input  logic                          data_in_service,
  output logic [63:0]                   hit_out,
  output logic                          hit_out_valid,
  output logic                          rdreg_dv,
  output logic [8:0]                    rdreg_addr,
  output logic [15:0]                   rdreg_data,
  output autoread_t [AR_SLOTS-1:0]      auto_read,
  output logic [AR_SLOTS-1:0]           auto_read_upd,
  output logic                          cb_seen,
  output logic                          idle_seen,
  output logic                          frame_err
);

  logic [1:0]                r_idx;
  logic [1:0]                w_idx_nxt;
  logic [1:0]                w_idx_inc;
  logic [7:0]                w_hdr;
  autoread_t                 w_hi;
  autoread_t                 w_lo;
  logic                      w_hit;
  logic                      w_idle;
  logic                      w_cb;
  logic                      w_err;
  logic                      w_ld1;
  logic                      w_ld2;
  logic                      w_ovf;
  logic [AR_SLOTS-1:0]       w_upd;
  autoread_t [AR_SLOTS-1:0]  w_slot;
  rdreg_t                    w_rd_a;
  rdreg_t                    w_rd_b;
  rdreg_t                    w_rd;

  assign w_hdr = data_in[63:56];
  assign w_hi  = data_in[51:26];
  assign w_lo  = data_in[25:0];
  assign w_idx_inc = (r_idx == 2'(SVC_FRAMES - 1)) ? r_idx : r_idx + 2'd1;

  // Read results: A from the upper field, B from the lower field.
  assign w_rd_a = '{addr: w_hi[24:16], data: w_hi[15:0]};
  assign w_rd_b = '{addr: w_lo[24:16], data: w_lo[15:0]};

  // Classify the incoming frame and work out slot writes and the next service index.
  always_comb begin
    w_hit     = 1'b0;
    w_idle    = 1'b0;
    w_cb      = 1'b0;
    w_err     = 1'b0;
    w_ld1     = 1'b0;
    w_ld2     = 1'b0;
    w_upd     = '0;
    w_slot    = '0;
    w_idx_nxt = r_idx;
    if (data_in_valid && !data_in_service) begin
      w_idx_nxt = '0;
      if (data_in == IDLE_FRAME) begin
        w_idle = 1'b1;
        w_hit  = !DROP_IDLE;
      end else begin
        w_hit  = 1'b1;
      end
    end else if (data_in_valid) begin
      w_idx_nxt = w_idx_inc;
      case (w_hdr)
        HDR_AR: begin
          w_upd[{r_idx, 1'b0}]  = 1'b1;
          w_upd[{r_idx, 1'b1}]  = 1'b1;
          w_slot[{r_idx, 1'b0}] = w_hi;
          w_slot[{r_idx, 1'b1}] = w_lo;
        end
        HDR_RR1: begin
          if (r_idx == 2'd0) begin
            w_ld1     = 1'b1;
            w_upd[0]  = 1'b1;
            w_slot[0] = w_lo;
          end else begin
            w_err = 1'b1;
          end
        end
        HDR_RR2: begin
          if (r_idx == 2'd0) w_ld2 = 1'b1;
          else               w_err = 1'b1;
        end
        HDR_CB: begin
          w_cb      = 1'b1;
          w_idx_nxt = '0;
        end
        default: w_err = 1'b1;
      endcase
    end
  end

  // Register all classifier outputs, the shadow slots and the service index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx         <= '0;
      hit_out       <= '0;
      hit_out_valid <= 1'b0;
      idle_seen     <= 1'b0;
      cb_seen       <= 1'b0;
      frame_err     <= 1'b0;
      auto_read_upd <= '0;
      auto_read     <= '0;
    end else begin
      r_idx         <= w_idx_nxt;
      hit_out_valid <= w_hit;
      if (w_hit) hit_out <= data_in;
      idle_seen     <= w_idle;
      cb_seen       <= w_cb;
      frame_err     <= w_err | w_ovf;
      auto_read_upd <= w_upd;
      for (int k = 0; k < AR_SLOTS; k++) begin
        if (w_upd[k]) auto_read[k] <= w_slot[k];
      end
    end
  end

  rdreg_serialiser u_rdreg (
    .clk     (clk),
    .reset   (reset),
    .i_load1 (w_ld1),
    .i_load2 (w_ld2),
    .i_rd_a  (w_rd_a),
    .i_rd_b  (w_rd_b),
    .o_ovf   (w_ovf),
    .o_dv    (rdreg_dv),
    .o_rd    (w_rd)
  );

  assign rdreg_addr = w_rd.addr;
  assign rdreg_data = w_rd.data;

endmodule
